// File: rtl/pipe_mem_ctrl.sv
// Pipeline control for the 5-stage CPU: operand forwarding, load-use interlock and data-memory handshake FSM.
// Optional feature macro: PIPE_MEM_CTRL_FWD_EN (defined = bypass network, undefined = interlock on every hazard).
module pipe_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_usert,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic       mwmem,
    input  logic [4:0] mrn,
    input  logic       dmem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       stall,
    output logic       bubble,
    output logic       pipe_hold,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             m_acc;
    logic             lu;
    logic             e_valid;
    logic             e_hit;

    // r0 is hardwired zero, so it never counts as a real destination
    assign e_valid = ewreg & (ern != 5'd0);
    assign e_hit   = (ern == id_rs) | (id_usert & (ern == id_rt));
    assign m_acc   = mm2reg | mwmem;

`ifdef PIPE_MEM_CTRL_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic m_match;
        m_match = mwreg & (mrn != 5'd0) & (mrn == src);
        if (e_valid & ~em2reg & (ern == src))
            fwd_sel = 2'b01;
        else if (m_match & ~mm2reg)
            fwd_sel = 2'b10;
        else if (m_match & mm2reg)
            fwd_sel = 2'b11;
        else
            fwd_sel = 2'b00;
    endfunction

    assign fwda = fwd_sel(id_rs);
    assign fwdb = fwd_sel(id_rt);
    assign lu   = e_valid & em2reg & e_hit;
`else
    logic m_valid;
    logic m_hit;

    // Without a bypass network every RAW hazard against EXE or MEM must interlock
    assign m_valid = mwreg & (mrn != 5'd0);
    assign m_hit   = (mrn == id_rs) | (id_usert & (mrn == id_rt));
    assign fwda    = 2'b00;
    assign fwdb    = 2'b00;
    assign lu      = (e_valid & e_hit) | (m_valid & m_hit);
`endif

    assign pipe_hold = m_acc & (state != DONE);
    assign stall     = pipe_hold | lu;
    assign bubble    = lu & ~pipe_hold;

    // Memory handshake: ack beats a same-cycle timeout, and reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= IDLE;
            count       <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_acc) begin
                        state    <= WAIT;
                        dmem_req <= 1'b1;
                        dmem_we  <= mwmem;
                        count    <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else if (count == LAST_CNT) begin
                        state       <= DONE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed testbench for pipe_mem_ctrl: hazard logic, memory handshake, timeout and reset abort.
// Expectations follow PIPE_MEM_CTRL_FWD_EN the same way the design does.
module tb_pipe_mem_ctrl;

    logic       clk;
    logic       clrn;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_usert;
    logic       ewreg;
    logic       em2reg;
    logic [4:0] ern;
    logic       mwreg;
    logic       mm2reg;
    logic       mwmem;
    logic [4:0] mrn;
    logic       dmem_ack;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       stall;
    logic       bubble;
    logic       pipe_hold;
    logic       timeout_err;

    int n_checks = 0;
    int n_fails  = 0;
    int hold_cnt;
    int req_cnt;
    int we_cnt;

    pipe_mem_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_usert   (id_usert),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .ern        (ern),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .mrn        (mrn),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .fwda       (fwda),
        .fwdb       (fwdb),
        .stall      (stall),
        .bubble     (bubble),
        .pipe_hold  (pipe_hold),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic usert);
        id_rs    = rs;
        id_rt    = rt;
        id_usert = usert;
    endtask

    task automatic set_exe(input logic wreg, input logic m2reg, input logic [4:0] rn);
        ewreg  = wreg;
        em2reg = m2reg;
        ern    = rn;
    endtask

    task automatic set_mem(input logic wreg, input logic m2reg, input logic wmem, input logic [4:0] rn);
        mwreg  = wreg;
        mm2reg = m2reg;
        mwmem  = wmem;
        mrn    = rn;
    endtask

    initial begin
        clrn     = 1'b0;
        dmem_ack = 1'b0;
        set_id(5'd0, 5'd0, 1'b0);
        set_exe(1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_req", 8'(dmem_req), 8'd0);
        check("reset_we", 8'(dmem_we), 8'd0);
        check("reset_terr", 8'(timeout_err), 8'd0);
        check("reset_hold", 8'(pipe_hold), 8'd0);
        check("reset_stall", 8'(stall), 8'd0);
        check("reset_fwda", 8'(fwda), 8'd0);
        clrn = 1'b1;

        // EXE ALU result feeding both operands
        @(negedge clk);
        set_exe(1'b1, 1'b0, 5'd5);
        set_id(5'd5, 5'd5, 1'b1);
        #1;
`ifdef PIPE_MEM_CTRL_FWD_EN
        check("exe_fwda", 8'(fwda), 8'd1);
        check("exe_fwdb", 8'(fwdb), 8'd1);
        check("exe_stall", 8'(stall), 8'd0);
`else
        check("exe_fwda", 8'(fwda), 8'd0);
        check("exe_fwdb", 8'(fwdb), 8'd0);
        check("exe_stall", 8'(stall), 8'd1);
        check("exe_bubble", 8'(bubble), 8'd1);
`endif

        // EXE beats MEM on the same register; MEM ALU on rt
        set_mem(1'b1, 1'b0, 1'b0, 5'd5);
        set_id(5'd5, 5'd6, 1'b1);
        #1;
`ifdef PIPE_MEM_CTRL_FWD_EN
        check("prio_fwda", 8'(fwda), 8'd1);
        check("prio_fwdb", 8'(fwdb), 8'd0);
`else
        check("prio_fwda", 8'(fwda), 8'd0);
        check("prio_stall", 8'(stall), 8'd1);
`endif

        set_exe(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 1'b0, 5'd9);
        set_id(5'd9, 5'd3, 1'b1);
        #1;
`ifdef PIPE_MEM_CTRL_FWD_EN
        check("mem_fwda", 8'(fwda), 8'd2);
        check("mem_fwdb", 8'(fwdb), 8'd0);
        check("mem_stall", 8'(stall), 8'd0);
`else
        check("mem_fwda", 8'(fwda), 8'd0);
        check("mem_stall", 8'(stall), 8'd1);
        check("mem_bubble", 8'(bubble), 8'd1);
`endif

        // r0 is never a hazard
        set_mem(1'b0, 1'b0, 1'b0, 5'd0);
        set_exe(1'b1, 1'b0, 5'd0);
        set_id(5'd0, 5'd0, 1'b1);
        #1;
        check("r0_fwda", 8'(fwda), 8'd0);
        check("r0_fwdb", 8'(fwdb), 8'd0);
        check("r0_stall", 8'(stall), 8'd0);

        // Load-use on rt, then with rt unused
        set_exe(1'b1, 1'b1, 5'd7);
        set_id(5'd1, 5'd7, 1'b1);
        #1;
        check("lu_stall", 8'(stall), 8'd1);
        check("lu_bubble", 8'(bubble), 8'd1);
        check("lu_fwdb", 8'(fwdb), 8'd0);
        id_usert = 1'b0;
        #1;
        check("lu_nort_stall", 8'(stall), 8'd0);
        check("lu_nort_bubble", 8'(bubble), 8'd0);

        // Load with ack in the third WAIT cycle
        @(negedge clk);
        set_exe(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 1'b0, 5'd4);
        set_id(5'd4, 5'd0, 1'b0);
        hold_cnt = 0;
        req_cnt  = 0;
        we_cnt   = 0;
        #1;
        check("ld_hold_idle", 8'(pipe_hold), 8'd1);
        check("ld_bubble_idle", 8'(bubble), 8'd0);
`ifdef PIPE_MEM_CTRL_FWD_EN
        check("ld_fwda", 8'(fwda), 8'd3);
`endif
        for (int i = 0; i < 6; i++) begin
            #1;
            hold_cnt += int'(pipe_hold);
            req_cnt  += int'(dmem_req);
            we_cnt   += int'(dmem_we);
            if (i == 4) check("ld_hold_done", 8'(pipe_hold), 8'd0);
            dmem_ack = (i == 3);
            if (i == 4) set_mem(1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
        end
        check("ld_hold_cycles", 8'(hold_cnt), 8'd4);
        check("ld_req_cycles", 8'(req_cnt), 8'd3);
        check("ld_we_cycles", 8'(we_cnt), 8'd0);
        check("ld_terr", 8'(timeout_err), 8'd0);

        // Store with no ack: times out after 4 WAIT cycles
        set_mem(1'b0, 1'b0, 1'b1, 5'd0);
        hold_cnt = 0;
        req_cnt  = 0;
        we_cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            hold_cnt += int'(pipe_hold);
            req_cnt  += int'(dmem_req);
            we_cnt   += int'(dmem_we);
            if (i == 5) begin
                check("to_hold_done", 8'(pipe_hold), 8'd0);
                check("to_terr_set", 8'(timeout_err), 8'd1);
                set_mem(1'b0, 1'b0, 1'b0, 5'd0);
            end
            @(negedge clk);
        end
        check("to_req_cycles", 8'(req_cnt), 8'd4);
        check("to_we_cycles", 8'(we_cnt), 8'd4);
        check("to_hold_cycles", 8'(hold_cnt), 8'd5);
        check("to_terr_sticky", 8'(timeout_err), 8'd1);

        // Reset in the middle of WAIT
        set_mem(1'b1, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        #1;
        check("rst_req_before", 8'(dmem_req), 8'd1);
        clrn = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_after", 8'(dmem_req), 8'd0);
        check("rst_terr_after", 8'(timeout_err), 8'd0);
        check("rst_hold_idle", 8'(pipe_hold), 8'd1);
        clrn = 1'b1;
        @(negedge clk);
        #1;
        check("rst_reissue", 8'(dmem_req), 8'd1);
        check("rst_reissue_we", 8'(dmem_we), 8'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);

        // Ack on the last allowed WAIT cycle wins over the timeout
        set_mem(1'b0, 1'b0, 1'b1, 5'd0);
        req_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            req_cnt += int'(dmem_req);
            dmem_ack = (i == 4);
            if (i == 5) set_mem(1'b0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
        end
        check("race_req_cycles", 8'(req_cnt), 8'd4);
        check("race_terr", 8'(timeout_err), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipe_mem_ctrl.md
Name: pipe_mem_ctrl

Overview:
- Pipeline control unit for the 5-stage CPU.
- Generates operand-forwarding selects and the load-use interlock (stall PC/IF-ID, bubble into ID/EXE).
- Sequences the data-memory handshake for the instruction sitting in the EXE/MEM pipeline register, freezing all pipeline registers until memory acknowledges or a timeout expires.

Parameters:
- TIMEOUT, 16: max WAIT cycles before a memory access is force-completed; legal range 2..256.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- clrn  in  1  synchronous active-low reset
- id_rs  in  5  source reg A of instruction in ID
- id_rt  in  5  source reg B of instruction in ID
- id_usert  in  1  1 = ID instruction reads rt
- ewreg  in  1  EXE instruction writes register file
- em2reg  in  1  EXE instruction is a load
- ern  in  5  EXE destination register
- mwreg  in  1  MEM instruction writes register file
- mm2reg  in  1  MEM instruction is a load
- mwmem  in  1  MEM instruction is a store
- mrn  in  5  MEM destination register
- dmem_ack  in  1  data memory completion, sampled in WAIT only
- dmem_req  out  1  registered memory request
- dmem_we  out  1  registered write enable, valid with dmem_req
- fwda  out  2  operand A select: 00 regfile, 01 EXE alu, 10 MEM alu, 11 MEM load data
- fwdb  out  2  operand B select, same encoding, against id_rt
- stall  out  1  1 = hold PC and IF/ID
- bubble  out  1  1 = load zeros (nop) into ID/EXE
- pipe_hold  out  1  1 = hold ID/EXE, EXE/MEM, MEM/WB
- timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (clrn=0 at rising edge):
  - state=IDLE, counter=0, dmem_req=0, dmem_we=0, timeout_err=0.
  - Combinational outputs follow their equations from the reset state.
  - Reset during WAIT aborts the access; dmem_req is 0 after that edge.
- Register r is a "valid destination" only if r != 0; r0 never matches.
- Forwarding (combinational, fwda shown; fwdb identical with id_rt):
  - 01 if ewreg & ~em2reg & ern valid & ern==id_rs.
  - Else 10 if mwreg & ~mm2reg & mrn match.
  - Else 11 if mwreg & mm2reg & mrn match.
  - Else 00.
  - EXE match has priority over MEM match.
- Load-use: lu = ewreg & em2reg & ern valid & (ern==id_rs | (id_usert & ern==id_rt)).
- m_acc = mm2reg | mwmem.
- FSM states IDLE, WAIT, DONE:
  - IDLE: if m_acc, next=WAIT, set dmem_req=1 and dmem_we=mwmem on that edge, counter=0.
  - WAIT: if dmem_ack, next=DONE and dmem_req=0. Else if counter==TIMEOUT-1, next=DONE, dmem_req=0, timeout_err=1. Else counter+1.
  - DONE: next=IDLE unconditionally; the pipeline advances this cycle.
  - dmem_ack outside WAIT is ignored.
  - Ack and timeout in the same cycle: the ack wins; timeout_err is not set.
- Hold and interlock equations:
  - pipe_hold = m_acc & (state != DONE).
  - stall = pipe_hold | lu.
  - bubble = lu & ~pipe_hold; a hold suppresses bubbles so nothing is lost.
- Latency:
  - Zero-wait memory (ack in first WAIT cycle): 3 cycles per memory instruction.
  - Each extra wait cycle adds 1.
  - Timeout completes after TIMEOUT WAIT cycles.
- Back-to-back memory ops: DONE advances the pipe; the next op is seen in IDLE on the following cycle.

Optional Feature:
- Macro PIPE_MEM_CTRL_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - fwda and fwdb are tied to 00.
  - lu is extended to any ID source matching a valid ern (ewreg) or mrn (mwreg), giving stall+bubble instead of a bypass.
  - Memory FSM is unchanged.

Test Plan:
- ewreg=1, em2reg=0, ern=5, id_rs=5, id_rt=5, id_usert=1 -> fwda=01, fwdb=01, stall=0.
- ern=0 with ewreg=1, id_rs=0 -> fwda=00 (r0 never forwarded).
- em2reg=1, ewreg=1, ern=7, id_rt=7, id_usert=1, mwmem=mm2reg=0 -> stall=1, bubble=1 for one cycle. With id_usert=0 -> stall=0.
- mm2reg=1, dmem_ack returned 2 cycles after dmem_req:
  - pipe_hold=1 for 4 cycles, then 0 in DONE.
  - dmem_req high exactly 3 cycles.
  - dmem_we=0 throughout.
- mwmem=1, TIMEOUT=4, dmem_ack never asserted -> dmem_req high 4 cycles, DONE reached, timeout_err=1 and stays 1 until clrn=0.
- clrn=0 pulsed mid-WAIT -> next cycle state=IDLE, dmem_req=0, timeout_err=0. With m_acc still 1, a new request issues the cycle after reset is released.
